// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: data width, FSM encoding,
// legal byte-mask constants and the default response timeout.
package lsu_ctrl_pkg;

    localparam int WIDTH            = 64;
    localparam int RESP_TIMEOUT_DEF = 64;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_e;

    // A mask is usable only if it is one of the four natural sizes and stays inside the 8-byte word.
    function automatic logic mask_legal(input logic [7:0] mask, input logic [2:0] off);
        logic [3:0] span;
        case (mask)
            MASK_B:  span = 4'd1;
            MASK_H:  span = 4'd2;
            MASK_W:  span = 4'd4;
            MASK_D:  span = 4'd8;
            default: span = 4'd0;
        endcase
        return (span != 4'd0) && (({1'b0, off} + span) <= 4'd8);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Right-aligns the addressed bytes of a dmem read word, masks them to the access size
// and sign- or zero-extends the result.
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] i_rdata,
    input  logic [2:0]       i_offset,
    input  logic [7:0]       i_mask,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_load_data
);

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_bytemask;
    logic             w_sign;

    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        for (int i = 0; i < 8; i++) begin
            w_bytemask[8*i +: 8] = {8{i_mask[i]}};
        end
        case (i_mask)
            MASK_B:  w_sign = w_shifted[7];
            MASK_H:  w_sign = w_shifted[15];
            MASK_W:  w_sign = w_shifted[31];
            default: w_sign = 1'b0;
        endcase
        o_load_data = w_shifted & w_bytemask;
        if (i_signed && w_sign) begin
            o_load_data = o_load_data | ~w_bytemask;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one EX op at a time, runs the dmem request/response
// handshake for memory ops and presents a one-cycle result pulse to WB.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a new EX op
// REQ     | dmem_req asserted, payload held until dmem_gnt
// RESP    | granted, waiting for dmem_rvalid or the response timeout
// OUT     | mem_valid pulse for one cycle, then back to IDLE
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             flush,

    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic             ex_is_write_dmem,
    input  logic             ex_is_read_dmem,
    input  logic             ex_load_signed,
    input  logic [1:0]       ex_wb_select,
    input  logic [7:0]       ex_write_width,
    input  logic [WIDTH-1:0] ex_dmem_write_data,

    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [7:0]       dmem_wstrb,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_err,

    output logic             mem_valid,
    output logic [1:0]       mem_wb_select,
    output logic [WIDTH-1:0] mem_alu_result,
    output logic [WIDTH-1:0] mem_load_data,
    output logic             mem_err
);

    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;

    logic [WIDTH-1:0] r_addr;
    logic [7:0]       r_mask;
    logic [WIDTH-1:0] r_wdata;
    logic             r_is_write;
    logic             r_signed;
    logic [1:0]       r_wb_select;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic [1:0]       r_mem_wb_select;
    logic [WIDTH-1:0] r_mem_alu_result;
    logic [WIDTH-1:0] r_mem_load_data;
    logic             r_mem_err;

    logic             w_ex_mem;
    logic             w_accept;
    logic             w_enter_resp;
    logic             w_tmo;
    logic             w_flush_pend_nxt;
    logic             w_out_load;
    logic             w_out_from_ex;
    logic             w_out_err;
    logic [WIDTH-1:0] w_out_data;
    logic [WIDTH-1:0] w_align_data;
    logic [WIDTH-1:0] w_load_data;

    lsu_load_align u_load_align (
        .i_rdata     (dmem_rdata),
        .i_offset    (r_addr[2:0]),
        .i_mask      (r_mask),
        .i_signed    (r_signed),
        .o_load_data (w_align_data)
    );

    assign w_ex_mem    = ex_is_write_dmem | ex_is_read_dmem;
    assign w_load_data = r_is_write ? '0 : w_align_data;
    assign w_tmo       = (r_state == ST_RESP) && (r_tmo_cnt == '0);

    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        w_enter_resp     = 1'b0;
        w_flush_pend_nxt = 1'b0;
        w_out_load       = 1'b0;
        w_out_from_ex    = 1'b0;
        w_out_err        = 1'b0;
        w_out_data       = '0;
        case (r_state)
            ST_IDLE: begin
                // A flush coinciding with acceptance cancels the op outright.
                if (ex_valid && !flush) begin
                    w_accept = 1'b1;
                    if (!w_ex_mem) begin
                        w_state_nxt   = ST_OUT;
                        w_out_load    = 1'b1;
                        w_out_from_ex = 1'b1;
                    end else if (!mask_legal(ex_write_width, ex_alu_result[2:0])) begin
                        w_state_nxt   = ST_OUT;
                        w_out_load    = 1'b1;
                        w_out_from_ex = 1'b1;
                        w_out_err     = 1'b1;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    if (dmem_rvalid) begin
                        if (flush) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_OUT;
                            w_out_load  = 1'b1;
                            w_out_err   = dmem_err;
                            w_out_data  = w_load_data;
                        end
                    end else begin
                        w_state_nxt      = ST_RESP;
                        w_enter_resp     = 1'b1;
                        w_flush_pend_nxt = flush;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                // A granted access cannot be withdrawn; a flush only discards its result.
                w_flush_pend_nxt = r_flush_pend | flush;
                if (dmem_rvalid || w_tmo) begin
                    if (r_flush_pend || flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_OUT;
                        w_out_load  = 1'b1;
                        w_out_err   = dmem_rvalid ? dmem_err : 1'b1;
                        w_out_data  = dmem_rvalid ? w_load_data : '0;
                    end
                end
            end
            ST_OUT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            if (w_enter_resp) begin
                r_tmo_cnt <= CNT_W'(RESP_TIMEOUT - 1);
            end else if ((r_state == ST_RESP) && (r_tmo_cnt != '0)) begin
                r_tmo_cnt <= r_tmo_cnt - CNT_W'(1);
            end else if (r_state != ST_RESP) begin
                r_tmo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_addr      <= '0;
            r_mask      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_signed    <= 1'b0;
            r_wb_select <= '0;
        end else if (w_accept) begin
            r_addr      <= ex_alu_result;
            r_mask      <= ex_write_width;
            r_wdata     <= ex_dmem_write_data;
            r_is_write  <= ex_is_write_dmem;
            r_signed    <= ex_load_signed;
            r_wb_select <= ex_wb_select;
        end
    end

    // WB payload changes only on entry to OUT so it holds between results.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_mem_wb_select  <= '0;
            r_mem_alu_result <= '0;
            r_mem_load_data  <= '0;
            r_mem_err        <= 1'b0;
        end else if (w_out_load) begin
            r_mem_wb_select  <= w_out_from_ex ? ex_wb_select  : r_wb_select;
            r_mem_alu_result <= w_out_from_ex ? ex_alu_result : r_addr;
            r_mem_load_data  <= w_out_data;
            r_mem_err        <= w_out_err;
        end
    end

    assign ex_ready       = (r_state == ST_IDLE);
    assign dmem_req       = (r_state == ST_REQ);
    assign dmem_we        = (r_state == ST_REQ) && r_is_write;
    assign dmem_addr      = {r_addr[WIDTH-1:3], 3'b000};
    assign dmem_wstrb     = r_mask << r_addr[2:0];
    assign dmem_wdata     = r_wdata << {r_addr[2:0], 3'b000};

    assign mem_valid      = (r_state == ST_OUT) && !flush;
    assign mem_wb_select  = r_mem_wb_select;
    assign mem_alu_result = r_mem_alu_result;
    assign mem_load_data  = r_mem_load_data;
    assign mem_err        = r_mem_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: ALU pass-through, stores, aligned loads, illegal masks,
// timeout, flush in each state and reset mid-access.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic             sys_clk;
    logic             sys_rst;
    logic             flush;
    logic             ex_valid;
    logic             ex_ready;
    logic [WIDTH-1:0] ex_alu_result;
    logic             ex_is_write_dmem;
    logic             ex_is_read_dmem;
    logic             ex_load_signed;
    logic [1:0]       ex_wb_select;
    logic [7:0]       ex_write_width;
    logic [WIDTH-1:0] ex_dmem_write_data;
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic [7:0]       dmem_wstrb;
    logic             dmem_gnt;
    logic             dmem_rvalid;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_err;
    logic             mem_valid;
    logic [1:0]       mem_wb_select;
    logic [WIDTH-1:0] mem_alu_result;
    logic [WIDTH-1:0] mem_load_data;
    logic             mem_err;

    int checks;
    int errors;

    lsu_ctrl #(.RESP_TIMEOUT(64)) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .flush              (flush),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_alu_result      (ex_alu_result),
        .ex_is_write_dmem   (ex_is_write_dmem),
        .ex_is_read_dmem    (ex_is_read_dmem),
        .ex_load_signed     (ex_load_signed),
        .ex_wb_select       (ex_wb_select),
        .ex_write_width     (ex_write_width),
        .ex_dmem_write_data (ex_dmem_write_data),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_wstrb         (dmem_wstrb),
        .dmem_gnt           (dmem_gnt),
        .dmem_rvalid        (dmem_rvalid),
        .dmem_rdata         (dmem_rdata),
        .dmem_err           (dmem_err),
        .mem_valid          (mem_valid),
        .mem_wb_select      (mem_wb_select),
        .mem_alu_result     (mem_alu_result),
        .mem_load_data      (mem_load_data),
        .mem_err            (mem_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Present one op for a single cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [63:0] alu, input logic wr, input logic rd,
                         input logic sgn, input logic [1:0] wb, input logic [7:0] mask,
                         input logic [63:0] wdata);
        ex_valid           = 1'b1;
        ex_alu_result      = alu;
        ex_is_write_dmem   = wr;
        ex_is_read_dmem    = rd;
        ex_load_signed     = sgn;
        ex_wb_select       = wb;
        ex_write_width     = mask;
        ex_dmem_write_data = wdata;
        tick();
        ex_valid = 1'b0;
    endtask

    logic saw_valid;

    initial begin
        checks = 0;
        errors = 0;
        sys_rst = 1'b0;
        flush = 1'b0;
        ex_valid = 1'b0;
        ex_alu_result = '0;
        ex_is_write_dmem = 1'b0;
        ex_is_read_dmem = 1'b0;
        ex_load_signed = 1'b0;
        ex_wb_select = 2'd0;
        ex_write_width = 8'h00;
        ex_dmem_write_data = '0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        dmem_err = 1'b0;

        tick();
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_alu", mem_alu_result, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wstrb", 64'(dmem_wstrb), 64'd0);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        sys_rst = 1'b1;
        tick();

        // ALU op
        issue(64'h1234, 1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 64'd0);
        chk("alu_valid", 64'(mem_valid), 64'd1);
        chk("alu_result", mem_alu_result, 64'h1234);
        chk("alu_wbsel", 64'(mem_wb_select), 64'd2);
        chk("alu_noreq", 64'(dmem_req), 64'd0);
        chk("alu_busy", 64'(ex_ready), 64'd0);
        tick();
        chk("alu_pulse", 64'(mem_valid), 64'd0);
        chk("alu_ready", 64'(ex_ready), 64'd1);
        chk("alu_hold", mem_alu_result, 64'h1234);

        // Byte store at offset 3, grant after two cycles, rvalid one cycle later
        issue(64'h1003, 1'b1, 1'b0, 1'b0, 2'd0, 8'h01, 64'hAB);
        chk("st_req", 64'(dmem_req), 64'd1);
        chk("st_we", 64'(dmem_we), 64'd1);
        chk("st_addr", dmem_addr, 64'h1000);
        chk("st_wstrb", 64'(dmem_wstrb), 64'h08);
        chk("st_wdata", dmem_wdata, 64'hAB00_0000);
        tick();
        chk("st_req_hold", 64'(dmem_req), 64'd1);
        chk("st_addr_hold", dmem_addr, 64'h1000);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("st_resp_noreq", 64'(dmem_req), 64'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        chk("st_valid", 64'(mem_valid), 64'd1);
        chk("st_err", 64'(mem_err), 64'd0);
        chk("st_ldata", mem_load_data, 64'd0);
        tick();

        // Signed halfword load at offset 6, gnt and rvalid in the same cycle
        issue(64'h2006, 1'b0, 1'b1, 1'b1, 2'd1, 8'h03, 64'd0);
        chk("lds_we", 64'(dmem_we), 64'd0);
        chk("lds_wstrb", 64'(dmem_wstrb), 64'hC0);
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 64'h8001_0000_0000_0000;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        chk("lds_valid", 64'(mem_valid), 64'd1);
        chk("lds_data", mem_load_data, 64'hFFFF_FFFF_FFFF_8001);
        chk("lds_alu", mem_alu_result, 64'h2006);
        tick();

        // Unsigned variant
        issue(64'h2006, 1'b0, 1'b1, 1'b0, 2'd1, 8'h03, 64'd0);
        dmem_gnt = 1'b1;
        dmem_rvalid = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        chk("ldu_data", mem_load_data, 64'h8001);
        tick();

        // Signed word load at offset 4 with a bus error
        issue(64'h2104, 1'b0, 1'b1, 1'b1, 2'd1, 8'h0F, 64'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_err = 1'b1;
        dmem_rdata = 64'h89AB_CDEF_0123_4567;
        tick();
        dmem_rvalid = 1'b0;
        dmem_err = 1'b0;
        chk("ldw_valid", 64'(mem_valid), 64'd1);
        chk("ldw_err", 64'(mem_err), 64'd1);
        chk("ldw_data", mem_load_data, 64'hFFFF_FFFF_89AB_CDEF);
        tick();

        // Word load crossing the 8-byte boundary
        issue(64'h0005, 1'b0, 1'b1, 1'b0, 2'd1, 8'h0F, 64'd0);
        chk("cross_noreq", 64'(dmem_req), 64'd0);
        chk("cross_valid", 64'(mem_valid), 64'd1);
        chk("cross_err", 64'(mem_err), 64'd1);
        tick();

        // Store with an illegal mask
        issue(64'h0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'h07, 64'h11);
        chk("badmask_noreq", 64'(dmem_req), 64'd0);
        chk("badmask_err", 64'(mem_err), 64'd1);
        tick();

        // Response timeout: 64 RESP cycles without rvalid
        issue(64'h3000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hFF, 64'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        saw_valid = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (mem_valid) saw_valid = 1'b1;
        end
        chk("tmo_early", 64'(saw_valid), 64'd0);
        tick();
        chk("tmo_valid", 64'(mem_valid), 64'd1);
        chk("tmo_err", 64'(mem_err), 64'd1);
        tick();

        // Flush during RESP, rvalid three cycles later
        issue(64'h4000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hFF, 64'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        saw_valid = 1'b0;
        tick();
        flush = 1'b0;
        if (mem_valid) saw_valid = 1'b1;
        tick();
        if (mem_valid) saw_valid = 1'b1;
        tick();
        if (mem_valid) saw_valid = 1'b1;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        if (mem_valid) saw_valid = 1'b1;
        chk("flresp_novalid", 64'(saw_valid), 64'd0);
        chk("flresp_ready", 64'(ex_ready), 64'd1);

        // Flush in REQ before grant
        issue(64'h4100, 1'b0, 1'b1, 1'b0, 2'd1, 8'hFF, 64'd0);
        chk("flreq_req", 64'(dmem_req), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flreq_drop", 64'(dmem_req), 64'd0);
        chk("flreq_ready", 64'(ex_ready), 64'd1);

        // Flush in the acceptance cycle
        flush = 1'b1;
        issue(64'h5555, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 64'd0);
        flush = 1'b0;
        chk("flacc_novalid", 64'(mem_valid), 64'd0);
        chk("flacc_ready", 64'(ex_ready), 64'd1);
        chk("flacc_hold", mem_alu_result, 64'h3000);

        // Flush in OUT suppresses the pulse
        issue(64'h0077, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 64'd0);
        flush = 1'b1;
        #1;
        chk("flout_novalid", 64'(mem_valid), 64'd0);
        tick();
        flush = 1'b0;

        // Reset mid-REQ, then a late rvalid
        issue(64'h6000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hFF, 64'd0);
        chk("rstreq_req", 64'(dmem_req), 64'd1);
        sys_rst = 1'b0;
        #1;
        chk("rstreq_drop", 64'(dmem_req), 64'd0);
        tick();
        sys_rst = 1'b1;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstreq_ready", 64'(ex_ready), 64'd1);
        chk("rstreq_novalid", 64'(mem_valid), 64'd0);
        chk("rstreq_alu", mem_alu_result, 64'd0);
        tick();
        chk("rstreq_still_idle", 64'(ex_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter RESP_TIMEOUT, default 64: cycles allowed between dmem grant and response before the access SHALL be reported as an error.
REQ-002 Port sys_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port sys_rst  in  1  one clock; reset is asynchronous and active-low.
REQ-004 Port flush  in  1  kills the in-flight operation.
REQ-005 EX-side inputs (all 1 bit unless noted): ex_valid; ex_ready (out); ex_alu_result (`width`, address or result); ex_is_write_dmem; ex_is_read_dmem; ex_load_signed; ex_wb_select (2 bits); ex_write_width (8-bit byte mask); ex_dmem_write_data (`width`).
REQ-006 dmem-side ports: dmem_req (out); dmem_we (out); dmem_addr (out, `width`, 8-byte aligned); dmem_wdata (out, `width`); dmem_wstrb (out, 8); dmem_gnt (in); dmem_rvalid (in); dmem_rdata (in, `width`); dmem_err (in).
REQ-007 WB-side outputs: mem_valid (1); mem_wb_select (2); mem_alu_result (`width`); mem_load_data (`width`); mem_err (1).

Function
REQ-008 FSM states SHALL be IDLE, REQ, RESP and OUT.
REQ-009 ex_ready SHALL be 1 only in IDLE; an op is accepted when ex_valid and ex_ready are both 1.
REQ-010 Non-memory op accepted in cycle N SHALL go to OUT and raise mem_valid in cycle N+1, with mem_alu_result equal to ex_alu_result.
REQ-011 Memory op accepted in cycle N SHALL go to REQ and raise dmem_req in cycle N+1.
REQ-012 dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_wstrb SHALL hold stable until dmem_gnt; the FSM SHALL then move to RESP.
REQ-013 Request payload: dmem_addr = address with bits [2:0] cleared; dmem_wstrb = mask << addr[2:0]; dmem_wdata = data << 8*addr[2:0].
REQ-014 Valid masks SHALL be 0x01, 0x03, 0x0F and 0xFF; any other mask, or a mask that crosses an 8-byte boundary, SHALL skip the bus access and go to OUT with mem_err = 1.
REQ-015 On dmem_rvalid in RESP, the FSM SHALL go to OUT; loads SHALL set mem_load_data = (rdata >> 8*addr[2:0]) & mask, sign-extended if ex_load_signed, else zero-extended; stores SHALL drive mem_load_data = 0.
REQ-016 If dmem_gnt and dmem_rvalid are high in the same REQ cycle, the access SHALL complete directly to OUT.
REQ-017 mem_err SHALL be set to dmem_err sampled with rvalid, or to 1 on a RESP_TIMEOUT expiry (counter reset on entering RESP).
REQ-018 OUT SHALL hold mem_valid high for exactly one cycle, then return to IDLE; mem_* outputs SHALL hold their values until the next OUT.
REQ-019 Flush handling:
  - in IDLE or OUT: mem_valid forced to 0 that cycle;
  - in REQ without gnt: dmem_req dropped next cycle, FSM returns to IDLE;
  - in RESP: FSM waits for rvalid or timeout, discards the result, then returns to IDLE without mem_valid.
REQ-020 A flush in the same cycle as acceptance SHALL cancel the accepted op.

Reset
REQ-021 On sys_rst low, the FSM SHALL go to IDLE asynchronously.
REQ-022 Reset values: dmem_req, dmem_we, mem_valid and mem_err = 0; all data, address, strobe and select outputs = 0; timeout counter = 0.
REQ-023 A reset during REQ or RESP SHALL abandon the access with no WB output; a late rvalid after reset SHALL be ignored in IDLE.

Structure
REQ-024 The FSM state encoding, legal mask constants and RESP_TIMEOUT default SHALL live in the shared para.v definitions alongside `width`.
REQ-025 Load alignment and extension (REQ-015) SHALL be one combinational sub-module, lsu_load_align.

Verification
REQ-026 ALU op, result 0x1234, valid at N -> mem_valid=1 at N+1 with mem_alu_result=0x1234, no dmem_req.
REQ-027 Store, addr 0x1003, mask 0x01, data 0xAB, gnt after 2 cycles, rvalid 1 cycle later -> dmem_addr=0x1000, wstrb=0x08, wdata=0xAB000000, then mem_valid with mem_err=0.
REQ-028 Signed load, addr 0x2006, mask 0x03, rdata=0x8001_0000_0000_0000 -> mem_load_data=0xFFFF_FFFF_FFFF_8001; the unsigned variant gives 0x8001.
REQ-029 Load, addr 0x0005, mask 0x0F -> no dmem_req, mem_valid with mem_err=1 one cycle after accept.
REQ-030 Load granted, no rvalid for 64 cycles -> mem_err=1 and mem_valid; separately, flush in RESP with rvalid 3 cycles later -> no mem_valid, ex_ready=1 next cycle.
REQ-031 sys_rst low mid-REQ -> dmem_req=0 immediately, ex_ready=1 after release.
